pipeline_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It tracks in-flight destination registers in an internal scoreboard shift register, one slot per post-ID stage. From that it generates operand-forwarding selects, load-use stalls, taken-branch flushes and multi-cycle (mul/div) freezes. It sits beside the ID stage and drives the IF/ID and ID/EX register enables and flushes, plus the EX operand muxes.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/hazard_scoreboard.sv | 50 +++++
 rtl/pipeline_hazard_unit.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard slot record, scoreboard ops, forward encoding.
package pipe_pkg;

    // Widest register address a scoreboard slot can hold; narrower addresses are zero-extended.
    localparam int unsigned SLOT_AW = 8;

    // Forward-select value meaning "take the operand from the register file".
    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] dest;
        logic               reg_write;
        logic               is_load;
    } slot_t;

    // Per-cycle scoreboard update: insert ID, freeze, insert bubble, or branch squash.
    typedef enum logic [1:0] {
        SB_ADVANCE = 2'd0,
        SB_HOLD    = 2'd1,
        SB_BUBBLE  = 2'd2,
        SB_FLUSH   = 2'd3
    } sb_op_t;

    // A slot produces src when it is a live register write to a non-zero register equal to src.
    function automatic logic slot_hit(input slot_t s, input logic [SLOT_AW-1:0] src);
        return s.valid && s.reg_write && (s.dest != '0) && (s.dest == src);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destination records, one slot per post-ID stage, with per-slot match flags.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned BR_SLOT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  sb_op_t             op_i,
    input  slot_t              ins_i,
    input  logic [SLOT_AW-1:0] src_a_i,
    input  logic [SLOT_AW-1:0] src_b_i,
    output logic [DEPTH-1:0]   match_a_o,
    output logic [DEPTH-1:0]   match_b_o,
    output logic               slot0_load_o,
    output logic               br_valid_o
);

    slot_t slots_q [DEPTH];
    slot_t slots_d [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        // Next value of slot k: youngest slot takes ID or a bubble; on a branch squash the
        // instructions younger than the branch are dropped as they move down.
        if (k == 0) begin : g_head
            assign slots_d[k] = (op_i == SB_ADVANCE) ? ins_i : '0;
        end else if (k <= BR_SLOT) begin : g_kill
            assign slots_d[k] = (op_i == SB_FLUSH) ? '0 : slots_q[k-1];
        end else begin : g_keep
            assign slots_d[k] = slots_q[k-1];
        end

        // Slot register; a freeze holds every slot in place.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slots_q[k] <= '0;
            end else if (op_i != SB_HOLD) begin
                slots_q[k] <= slots_d[k];
            end
        end

        assign match_a_o[k] = slot_hit(slots_q[k], src_a_i);
        assign match_b_o[k] = slot_hit(slots_q[k], src_b_i);
    end

    assign slot0_load_o = slots_q[0].valid && slots_q[0].is_load;
    assign br_valid_o   = slots_q[BR_SLOT].valid;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller: forward selects, load-use stall, branch flush, multi-cycle freeze.
module pipeline_hazard_unit
    import pipe_pkg::*;
#(
    parameter  int unsigned REG_AW     = 5,
    parameter  int unsigned FWD_DEPTH  = 3,
    parameter  int unsigned BR_SLOT    = 1,
    parameter  int unsigned MULDIV_LAT = 4,
    parameter  int unsigned SC_W       = 16,
    localparam int unsigned FS_W       = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_multi,
    input  logic              br_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              ex_hold,
    output logic [FS_W-1:0]   fwd_a_sel,
    output logic [FS_W-1:0]   fwd_b_sel,
    output logic [SC_W-1:0]   stall_cnt
);

    localparam int unsigned     MC_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MULDIV_LAT - 1);

    logic [MC_W-1:0]      mc_q, mc_d;
    logic [SC_W-1:0]      stall_cnt_q, stall_cnt_d;
    sb_op_t               sb_op;
    slot_t                ins;
    logic [SLOT_AW-1:0]   src_a, src_b;
    logic [FWD_DEPTH-1:0] match_a, match_b;
    logic                 slot0_load, br_valid;
    logic                 br_flush, luse;

    assign src_a = SLOT_AW'(id_rs);
    assign src_b = SLOT_AW'(id_rt);
    assign ins   = '{valid: id_valid, dest: SLOT_AW'(id_dest),
                     reg_write: id_reg_write, is_load: id_mem_read};

    hazard_scoreboard #(
        .DEPTH   (FWD_DEPTH),
        .BR_SLOT (BR_SLOT)
    ) u_sb (
        .clk          (clk),
        .rst_n        (reset),
        .op_i         (sb_op),
        .ins_i        (ins),
        .src_a_i      (src_a),
        .src_b_i      (src_b),
        .match_a_o    (match_a),
        .match_b_o    (match_b),
        .slot0_load_o (slot0_load),
        .br_valid_o   (br_valid)
    );

    // Youngest-match priority chain; index FWD_DEPTH is the register-file fallback.
    logic [FS_W-1:0] chain_a [FWD_DEPTH+1];
    logic [FS_W-1:0] chain_b [FWD_DEPTH+1];
    assign chain_a[FWD_DEPTH] = FS_W'(FWD_RF);
    assign chain_b[FWD_DEPTH] = FS_W'(FWD_RF);
    for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_fwd
        assign chain_a[k] = (id_uses_rs && match_a[k]) ? FS_W'(k + 1) : chain_a[k+1];
        assign chain_b[k] = (id_uses_rt && match_b[k]) ? FS_W'(k + 1) : chain_b[k+1];
    end
    assign fwd_a_sel = chain_a[0];
    assign fwd_b_sel = chain_b[0];

    // A load in EX can only feed ID once it reaches MEM, so a dependent reader waits one cycle.
    assign luse     = id_valid && slot0_load &&
                      ((id_uses_rs && match_a[0]) || (id_uses_rt && match_b[0]));
    assign br_flush = br_taken && br_valid;

    // Per-cycle decision: branch flush > multi-cycle freeze > load-use stall > advance.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        ex_hold     = 1'b0;
        sb_op       = SB_ADVANCE;
        mc_d        = mc_q;
        if (br_flush) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            sb_op       = SB_FLUSH;
            mc_d        = '0;
        end else if (mc_q != '0) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            ex_hold  = 1'b1;
            sb_op    = SB_HOLD;
            mc_d     = mc_q - MC_W'(1);
        end else if (luse) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            flush_id_ex = 1'b1;
            sb_op       = SB_BUBBLE;
        end else if (id_valid && id_multi) begin
            mc_d = MC_LOAD;
        end
    end

    // Saturating count of front-end stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
        end
    end

    // Multi-cycle countdown and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            mc_q        <= mc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed scenarios plus randomized traffic against a list model.
module tb_pipeline_hazard_unit;

    localparam int REG_AW = 5;
    localparam int D      = 3;
    localparam int BR     = 1;
    localparam int LAT    = 4;
    localparam int SC_W   = 16;
    localparam int FS_W   = $clog2(D + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_multi, br_taken;
    logic [REG_AW-1:0] id_rs, id_rt, id_dest;
    logic              stall_if, stall_id, flush_if_id, flush_id_ex, ex_hold;
    logic [FS_W-1:0]   fwd_a_sel, fwd_b_sel;
    logic [SC_W-1:0]   stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Model: list of in-flight instructions, index 0 = youngest (EX).
    bit m_v [D];
    int m_d [D];
    bit m_w [D];
    bit m_l [D];
    int m_mc;
    int m_sc;

    // Expected outputs and decision for the current cycle.
    bit e_sif, e_sid, e_fif, e_fie, e_hold, e_brf, e_frz, e_luse;
    int e_fa, e_fb, e_sc;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .REG_AW     (REG_AW),
        .FWD_DEPTH  (D),
        .BR_SLOT    (BR),
        .MULDIV_LAT (LAT),
        .SC_W       (SC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_multi     (id_multi),
        .br_taken     (br_taken),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .ex_hold      (ex_hold),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_cnt    (stall_cnt)
    );

    function automatic int exp_fwd(input int src, input bit uses);
        if (!uses || src == 0) return 0;
        for (int k = 0; k < D; k++)
            if (m_v[k] && m_w[k] && m_d[k] == src) return k + 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            m_v[k] = 0; m_d[k] = 0; m_w[k] = 0; m_l[k] = 0;
        end
        m_mc = 0;
        m_sc = 0;
    endtask

    task automatic model_eval();
        e_brf  = br_taken && m_v[BR];
        e_frz  = (m_mc != 0);
        e_luse = id_valid && m_v[0] && m_l[0] && m_w[0] && m_d[0] != 0 &&
                 ((id_uses_rs && m_d[0] == int'(id_rs)) || (id_uses_rt && m_d[0] == int'(id_rt)));
        {e_sif, e_sid, e_fif, e_fie, e_hold} = '0;
        if (e_brf) begin
            e_fif = 1; e_fie = 1;
        end else if (e_frz) begin
            e_sif = 1; e_sid = 1; e_hold = 1;
        end else if (e_luse) begin
            e_sif = 1; e_sid = 1; e_fie = 1;
        end
        e_fa = exp_fwd(int'(id_rs), id_uses_rs);
        e_fb = exp_fwd(int'(id_rt), id_uses_rt);
        e_sc = m_sc;
    endtask

    task automatic model_shift(input bit v, input int d, input bit w, input bit l);
        for (int k = D - 1; k > 0; k--) begin
            m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; m_w[k] = m_w[k-1]; m_l[k] = m_l[k-1];
        end
        m_v[0] = v; m_d[0] = d; m_w[0] = w; m_l[0] = l;
    endtask

    task automatic model_step();
        if (e_brf) begin
            for (int k = 0; k < BR; k++) m_v[k] = 0;
            model_shift(0, 0, 0, 0);
            m_mc = 0;
        end else if (e_frz) begin
            m_mc = m_mc - 1;
        end else if (e_luse) begin
            model_shift(0, 0, 0, 0);
        end else begin
            model_shift(id_valid, int'(id_dest), id_reg_write, id_mem_read);
            if (id_valid && id_multi) m_mc = LAT - 1;
        end
        if (e_sif && m_sc < (2 ** SC_W) - 1) m_sc = m_sc + 1;
    endtask

    // Advance one clock; returns just after the falling edge, ready for new inputs.
    task automatic cycle();
        model_eval();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int dest, input bit wr, input bit ld, input bit mul, input bit br);
        id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_dest = REG_AW'(dest);
        id_reg_write = wr; id_mem_read = ld; id_multi = mul; br_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        nop();
        @(negedge clk);
        @(negedge clk);
        model_clear();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1, 3, 3, 1, 1, 3, 1, 1, 1, 1);
        #1;
        n_total++; if (stall_if !== 1'b0) $display("FAIL reset_stall_if: got %b want 0", stall_if); else n_pass++;
        n_total++; if (stall_id !== 1'b0) $display("FAIL reset_stall_id: got %b want 0", stall_id); else n_pass++;
        n_total++; if (flush_if_id !== 1'b0) $display("FAIL reset_flush_if_id: got %b want 0", flush_if_id); else n_pass++;
        n_total++; if (flush_id_ex !== 1'b0) $display("FAIL reset_flush_id_ex: got %b want 0", flush_id_ex); else n_pass++;
        n_total++; if (ex_hold !== 1'b0) $display("FAIL reset_ex_hold: got %b want 0", ex_hold); else n_pass++;
        n_total++; if (fwd_a_sel !== '0) $display("FAIL reset_fwd_a: got %0d want 0", fwd_a_sel); else n_pass++;
        n_total++; if (fwd_b_sel !== '0) $display("FAIL reset_fwd_b: got %0d want 0", fwd_b_sel); else n_pass++;
        n_total++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        model_clear();
        reset = 1'b1;
        nop();
        #1;
        n_total++; if ({stall_if, ex_hold, flush_if_id} !== 3'b000 || stall_cnt !== '0)
            $display("FAIL post_reset_idle: stall_if=%b ex_hold=%b flush_if_id=%b stall_cnt=%0d want all 0",
                     stall_if, ex_hold, flush_if_id, stall_cnt);
        else n_pass++;
        cycle();
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        cycle();
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        #1;
        n_total++; if (fwd_a_sel !== FS_W'(1)) $display("FAIL fwd_from_ex: got %0d want 1", fwd_a_sel); else n_pass++;
        n_total++; if (stall_if !== 1'b0) $display("FAIL fwd_no_stall: got %b want 0", stall_if); else n_pass++;
        cycle();
        drive(1, 3, 0, 1, 0, 6, 1, 0, 0, 0);
        #1;
        n_total++; if (fwd_a_sel !== FS_W'(2)) $display("FAIL fwd_from_mem: got %0d want 2", fwd_a_sel); else n_pass++;
        cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        cycle();
        drive(1, 0, 5, 0, 1, 7, 1, 0, 0, 0);
        #1;
        n_total++; if ({stall_if, stall_id, flush_id_ex} !== 3'b111)
            $display("FAIL luse_stall: stall_if/stall_id/flush_id_ex=%b%b%b want 111", stall_if, stall_id, flush_id_ex);
        else n_pass++;
        cycle();
        #1;
        n_total++; if (stall_if !== 1'b0) $display("FAIL luse_one_cycle: stall_if=%b want 0", stall_if); else n_pass++;
        n_total++; if (fwd_b_sel !== FS_W'(2)) $display("FAIL luse_fwd_mem: got %0d want 2", fwd_b_sel); else n_pass++;
        n_total++; if (stall_cnt !== SC_W'(1)) $display("FAIL luse_stall_cnt: got %0d want 1", stall_cnt); else n_pass++;
        cycle();
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        n_total++; if ({flush_if_id, flush_id_ex} !== 2'b00)
            $display("FAIL br_ignored: flush_if_id/flush_id_ex=%b%b want 00", flush_if_id, flush_id_ex);
        else n_pass++;
        cycle();
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        cycle();
        drive(1, 9, 0, 1, 0, 10, 1, 0, 0, 1);
        #1;
        n_total++; if ({flush_if_id, flush_id_ex, stall_if, stall_id} !== 4'b1100)
            $display("FAIL br_flush: flush_if_id/flush_id_ex/stall_if/stall_id=%b%b%b%b want 1100",
                     flush_if_id, flush_id_ex, stall_if, stall_id);
        else n_pass++;
        cycle();
        drive(1, 9, 10, 1, 1, 11, 1, 0, 0, 0);
        #1;
        n_total++; if (fwd_a_sel !== '0) $display("FAIL br_killed_ex: fwd_a_sel=%0d want 0", fwd_a_sel); else n_pass++;
        n_total++; if (fwd_b_sel !== '0) $display("FAIL br_not_inserted: fwd_b_sel=%0d want 0", fwd_b_sel); else n_pass++;
        cycle();
    endtask

    task automatic test_muldiv();
        do_reset();
        drive(1, 0, 0, 0, 0, 8, 1, 0, 1, 0);
        #1;
        n_total++; if ({ex_hold, stall_if} !== 2'b00) $display("FAIL mc_start: ex_hold/stall_if=%b%b want 00", ex_hold, stall_if); else n_pass++;
        cycle();
        drive(1, 8, 0, 1, 0, 11, 1, 0, 0, 0);
        for (int i = 0; i < LAT - 1; i++) begin
            #1;
            n_total++; if ({ex_hold, stall_if} !== 2'b11)
                $display("FAIL mc_freeze_%0d: ex_hold/stall_if=%b%b want 11", i, ex_hold, stall_if);
            else n_pass++;
            cycle();
        end
        #1;
        n_total++; if ({ex_hold, stall_if} !== 2'b00) $display("FAIL mc_resume: ex_hold/stall_if=%b%b want 00", ex_hold, stall_if); else n_pass++;
        n_total++; if (fwd_a_sel !== FS_W'(1)) $display("FAIL mc_fwd: fwd_a_sel=%0d want 1", fwd_a_sel); else n_pass++;
        n_total++; if (stall_cnt !== SC_W'(LAT - 1)) $display("FAIL mc_stall_cnt: got %0d want %0d", stall_cnt, LAT - 1); else n_pass++;
        cycle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        drive(1, 0, 0, 1, 1, 14, 1, 0, 0, 0);
        #1;
        n_total++; if ({fwd_a_sel, fwd_b_sel} !== '0)
            $display("FAIL zero_fwd: fwd_a_sel=%0d fwd_b_sel=%0d want 0 0", fwd_a_sel, fwd_b_sel);
        else n_pass++;
        n_total++; if (stall_if !== 1'b0) $display("FAIL zero_no_stall: stall_if=%b want 0", stall_if); else n_pass++;
        cycle();
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        drive(1, 0, 0, 0, 0, 8, 1, 0, 1, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
        cycle();
        #1;
        n_total++; if (ex_hold !== 1'b1) $display("FAIL mid_freeze_hold: ex_hold=%b want 1", ex_hold); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if ({stall_if, stall_id, flush_if_id, flush_id_ex, ex_hold} !== 5'b0)
            $display("FAIL mid_freeze_reset_ctl: %b%b%b%b%b want 00000",
                     stall_if, stall_id, flush_if_id, flush_id_ex, ex_hold);
        else n_pass++;
        n_total++; if (stall_cnt !== '0) $display("FAIL mid_freeze_reset_cnt: got %0d want 0", stall_cnt); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        model_clear();
        reset = 1'b1;
        drive(1, 8, 0, 1, 0, 12, 1, 0, 0, 0);
        #1;
        n_total++; if ({stall_if, ex_hold} !== 2'b00 || fwd_a_sel !== '0)
            $display("FAIL after_reset_advance: stall_if=%b ex_hold=%b fwd_a_sel=%0d want 0 0 0",
                     stall_if, ex_hold, fwd_a_sel);
        else n_pass++;
        cycle();
        drive(1, 12, 0, 1, 0, 15, 1, 0, 0, 0);
        #1;
        n_total++; if (fwd_a_sel !== FS_W'(1)) $display("FAIL after_reset_fwd: fwd_a_sel=%0d want 1", fwd_a_sel); else n_pass++;
        cycle();
    endtask

    task automatic test_random();
        bit wr;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            wr = ($urandom_range(0, 9) < 7);
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), wr,
                  wr && ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0));
            #1;
            model_eval();
            n_total++; if (stall_if !== e_sif) $display("FAIL rnd_stall_if c%0d: got %b want %b", c, stall_if, e_sif); else n_pass++;
            n_total++; if (stall_id !== e_sid) $display("FAIL rnd_stall_id c%0d: got %b want %b", c, stall_id, e_sid); else n_pass++;
            n_total++; if (flush_if_id !== e_fif) $display("FAIL rnd_flush_if_id c%0d: got %b want %b", c, flush_if_id, e_fif); else n_pass++;
            n_total++; if (flush_id_ex !== e_fie) $display("FAIL rnd_flush_id_ex c%0d: got %b want %b", c, flush_id_ex, e_fie); else n_pass++;
            n_total++; if (ex_hold !== e_hold) $display("FAIL rnd_ex_hold c%0d: got %b want %b", c, ex_hold, e_hold); else n_pass++;
            n_total++; if (fwd_a_sel !== FS_W'(e_fa)) $display("FAIL rnd_fwd_a c%0d: got %0d want %0d", c, fwd_a_sel, e_fa); else n_pass++;
            n_total++; if (fwd_b_sel !== FS_W'(e_fb)) $display("FAIL rnd_fwd_b c%0d: got %0d want %0d", c, fwd_b_sel, e_fb); else n_pass++;
            n_total++; if (stall_cnt !== SC_W'(e_sc)) $display("FAIL rnd_stall_cnt c%0d: got %0d want %0d", c, stall_cnt, e_sc); else n_pass++;
            cycle();
        end
    endtask

    initial begin
        reset = 1'b0;
        nop();
        model_clear();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_muldiv();
        test_zero_reg();
        test_reset_mid_freeze();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
